// File: rtl/scope_trig_ctrl.sv
// Host-commanded trigger/capture sequencer between a UART byte link and an ADC sample stream.
// Latency: command effects and replies 1 cycle after rx_valid; trigger sample written 1 cycle after it arrives.
// Backpressure: single-entry response register; replies made while it is full are dropped and flagged in tx_ovf.
module scope_trig_ctrl #(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [15:0]       sample,
  input  logic              sample_valid,
  input  logic              ext_trig,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic [15:0]       trig_level,
  output logic              trig_edge,
  output logic [15:0]       cap_len,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ARMED = 2'd1, ST_CAPTURE = 2'd2, ST_DONE = 2'd3} cap_state_t;
  typedef enum logic [2:0] {P_CMD, P_PAY0, P_PAY1, P_PAY2, P_PAY3} parse_state_t;

  localparam logic [7:0] C_A = 8'h41, C_R = 8'h52, C_F = 8'h46, C_S = 8'h53, C_Q = 8'h3F;
  localparam logic [7:0] C_K = 8'h4B, C_B = 8'h42, C_E = 8'h45, C_D = 8'h44;
  // Longest capture that cannot overwrite itself; 16-bit length field saturates at 0xFFFF.
  localparam logic [16:0] MAX_LEN = (ADDR_W >= 16) ? 17'h0FFFF : 17'(2 ** ADDR_W);
  localparam int          TO_W    = $clog2(TIMEOUT + 1) + 1;

  cap_state_t        r_state;
  parse_state_t      r_pstate;
  logic [TO_W-1:0]   r_to_cnt;
  logic [15:0]       r_lvl;
  logic [7:0]        r_len_hi;
  logic              r_pay_edge;
  logic signed [15:0] r_prev;
  logic              r_prev_vld;
  logic              r_ext_d;
  logic              r_ext_pend;
  logic [16:0]       r_wcnt;
  logic              tx_ovf;

  logic              w_cmd_byte, w_pay_done, w_idle_done, w_stop, w_arm, w_status;
  logic [15:0]       w_len, w_len_clamp;
  logic signed [15:0] w_smp, w_lvl;
  logic              w_cross, w_ext_edge, w_fire, w_cap_end, w_d_evt;
  logic              w_cmd_rsp_vld, w_rsp_vld, w_slot_free, w_ovf_set;
  logic [7:0]        w_cmd_rsp, w_rsp_dat;

  assign state       = r_state;
  assign w_cmd_byte  = rx_valid && (r_pstate == P_CMD);
  assign w_pay_done  = rx_valid && (r_pstate == P_PAY3);
  assign w_idle_done = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_stop      = w_cmd_byte && (rx_data == C_S);
  assign w_arm       = w_cmd_byte && (rx_data == C_A) && w_idle_done;
  assign w_status    = w_cmd_byte && (rx_data == C_Q);
  assign w_len       = {r_len_hi, rx_data};
  assign w_len_clamp = ({1'b0, w_len} > MAX_LEN) ? MAX_LEN[15:0] : w_len;

  assign w_smp      = sample;
  assign w_lvl      = trig_level;
  assign w_cross    = trig_edge ? ((r_prev < w_lvl) && (w_smp >= w_lvl))
                                : ((r_prev >= w_lvl) && (w_smp < w_lvl));
  assign w_ext_edge = ext_trig && !r_ext_d;
  assign w_fire     = (r_state == ST_ARMED) && sample_valid &&
                      ((r_prev_vld && w_cross) || w_ext_edge || r_ext_pend);
  assign w_cap_end  = (r_state == ST_CAPTURE) && (r_wcnt == {1'b0, cap_len});
  assign w_d_evt    = w_cap_end || (w_fire && (cap_len == 16'd0));

  // Decode the reply byte produced by this cycle's command or completed payload.
  always_comb begin
    w_cmd_rsp_vld = 1'b0;
    w_cmd_rsp     = 8'h00;
    if (w_pay_done) begin
      w_cmd_rsp_vld = 1'b1;
      w_cmd_rsp     = w_idle_done ? C_K : C_B;
    end else if (w_cmd_byte) begin
      case (rx_data)
        C_R, C_F: w_cmd_rsp_vld = 1'b0;
        C_A: begin w_cmd_rsp_vld = 1'b1; w_cmd_rsp = w_idle_done ? C_K : C_B; end
        C_S: begin w_cmd_rsp_vld = 1'b1; w_cmd_rsp = C_K; end
        C_Q: begin w_cmd_rsp_vld = 1'b1; w_cmd_rsp = {3'b001, tx_ovf, trig_edge, 1'b0, r_state}; end
        default: begin w_cmd_rsp_vld = 1'b1; w_cmd_rsp = C_E; end
      endcase
    end
  end

  // Command replies take the slot over a same-cycle 'D'; the loser counts as an overflow.
  assign w_rsp_vld   = w_cmd_rsp_vld || w_d_evt;
  assign w_rsp_dat   = w_cmd_rsp_vld ? w_cmd_rsp : C_D;
  assign w_slot_free = !tx_valid || tx_ready;
  assign w_ovf_set   = (w_rsp_vld && !w_slot_free) || (w_cmd_rsp_vld && w_d_evt);

  // Byte parser: collects the 4-byte trigger payload and abandons it after an idle gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pstate   <= P_CMD;
      r_to_cnt   <= '0;
      r_lvl      <= 16'h0000;
      r_len_hi   <= 8'h00;
      r_pay_edge <= 1'b1;
    end else if (r_pstate == P_CMD) begin
      if (rx_valid && ((rx_data == C_R) || (rx_data == C_F))) begin
        r_pstate   <= P_PAY0;
        r_pay_edge <= (rx_data == C_R);
        r_to_cnt   <= '0;
      end
    end else if (rx_valid) begin
      r_to_cnt <= '0;
      case (r_pstate)
        P_PAY0:  begin r_lvl[15:8] <= rx_data; r_pstate <= P_PAY1; end
        P_PAY1:  begin r_lvl[7:0]  <= rx_data; r_pstate <= P_PAY2; end
        P_PAY2:  begin r_len_hi    <= rx_data; r_pstate <= P_PAY3; end
        default: r_pstate <= P_CMD;
      endcase
    end else if (r_to_cnt >= TO_W'(TIMEOUT)) begin
      r_pstate <= P_CMD;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Capture FSM, trigger detection, write sequencing and config; commands override the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 16'h0000;
      trig_level <= 16'h0000;
      trig_edge  <= 1'b1;
      cap_len    <= MAX_LEN[15:0];
      r_prev     <= 16'sh0000;
      r_prev_vld <= 1'b0;
      r_ext_d    <= 1'b0;
      r_ext_pend <= 1'b0;
      r_wcnt     <= 17'd0;
    end else begin
      r_ext_d <= ext_trig;
      wr_en   <= 1'b0;
      case (r_state)
        ST_ARMED: begin
          if (sample_valid) begin
            r_prev     <= w_smp;
            r_prev_vld <= 1'b1;
          end else if (w_ext_edge) begin
            r_ext_pend <= 1'b1;
          end
          if (w_fire) begin
            r_ext_pend <= 1'b0;
            if (cap_len == 16'd0) begin
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_CAPTURE;
              wr_en   <= 1'b1;
              wr_addr <= '0;
              wr_data <= sample;
              r_wcnt  <= 17'd1;
            end
          end
        end
        ST_CAPTURE: begin
          if (w_cap_end) begin
            r_state <= ST_DONE;
          end else if (sample_valid) begin
            wr_en   <= 1'b1;
            wr_addr <= wr_addr + 1'b1;
            wr_data <= sample;
            r_wcnt  <= r_wcnt + 17'd1;
          end
        end
        default: ;
      endcase
      if (w_stop) begin
        r_state <= ST_IDLE;
        wr_en   <= 1'b0;
      end
      if (w_arm) begin
        r_state    <= ST_ARMED;
        r_prev_vld <= 1'b0;
        r_ext_pend <= 1'b0;
      end
      if (w_pay_done && w_idle_done) begin
        trig_level <= r_lvl;
        trig_edge  <= r_pay_edge;
        cap_len    <= w_len_clamp;
      end
    end
  end

  // Single-entry response register with sticky overflow flag, cleared by a status read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      tx_ovf   <= 1'b0;
    end else begin
      if (w_rsp_vld && w_slot_free) begin
        tx_valid <= 1'b1;
        tx_data  <= w_rsp_dat;
      end else if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
      end
      if (w_ovf_set) tx_ovf <= 1'b1;
      else if (w_status) tx_ovf <= 1'b0;
    end
  end

endmodule
